// File: rtl/mem_port_arb_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
package mem_port_arb_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MAX_STREAK = 4;

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_MA   = 2'd2
  } rsp_e;

endpackage

// File: rtl/mem_arb_fair.sv
// Fixed-priority MA-over-IF grant with a streak limiter so fetch cannot starve.
// Grants are combinational on requests; only the streak count is registered; no grant while in reset.
module mem_arb_fair
  import mem_port_arb_pkg::*;
#(
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic ma_req,
  output logic if_gnt,
  output logic ma_gnt
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          if_turn;

  always_comb begin
    if_turn  = (streak_q == STREAK_MAX);
    ma_gnt   = rst_n & ma_req & ~(if_req & if_turn);
    if_gnt   = rst_n & if_req & ~ma_gnt;
    streak_d = streak_q;
    // Only MA wins that actually make fetch wait count toward the streak.
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (ma_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one synchronous single-port memory between fetch (IF) and data (MA) requesters.
// Grant same cycle, read data one cycle later; requesters hold until granted, one grant per cycle.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_if_req,
  input  logic [ADDR_W-1:0] iw_if_addr,
  output logic              ow_if_gnt,
  output logic              ow_if_rvalid,
  output logic [DATA_W-1:0] ow_if_rdata,
  input  logic              iw_ma_req,
  input  logic              iw_ma_we,
  input  logic [ADDR_W-1:0] iw_ma_addr,
  input  logic [DATA_W-1:0] iw_ma_wdata,
  output logic              ow_ma_gnt,
  output logic              ow_ma_rvalid,
  output logic [DATA_W-1:0] ow_ma_rdata,
  input  logic              iw_flush,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  input  logic [DATA_W-1:0] iw_mem_rdata
);

  rsp_e rsp_q;
  rsp_e rsp_d;
  logic flushed_q;
  logic flushed_d;

  mem_arb_fair #(
    .MAX_STREAK(MAX_STREAK)
  ) u_fair (
    .clk   (iw_clk),
    .rst_n (iw_rst),
    .if_req(iw_if_req),
    .ma_req(iw_ma_req),
    .if_gnt(ow_if_gnt),
    .ma_gnt(ow_ma_gnt)
  );

  always_comb begin
    ow_mem_we    = ow_ma_gnt & iw_ma_we;
    ow_mem_addr  = '0;
    ow_mem_wdata = '0;
    if (ow_ma_gnt) begin
      ow_mem_addr  = iw_ma_addr;
      ow_mem_wdata = iw_ma_wdata;
    end else if (ow_if_gnt) begin
      ow_mem_addr  = iw_if_addr;
    end

    rsp_d = RSP_IDLE;
    if (ow_if_gnt) begin
      rsp_d = RSP_IF;
    end else if (ow_ma_gnt && !iw_ma_we) begin
      rsp_d = RSP_MA;
    end

    // A fetch granted alongside the flush belongs to the new stream and stays unmasked.
    flushed_d = iw_flush & ~ow_if_gnt;

    ow_if_rvalid = (rsp_q == RSP_IF) & ~flushed_q & ~iw_flush;
    ow_ma_rvalid = (rsp_q == RSP_MA);
    ow_if_rdata  = ow_if_rvalid ? iw_mem_rdata : '0;
    ow_ma_rdata  = ow_ma_rvalid ? iw_mem_rdata : '0;
  end

  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      rsp_q     <= RSP_IDLE;
      flushed_q <= 1'b0;
    end else begin
      rsp_q     <= rsp_d;
      flushed_q <= flushed_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: behavioural memory, transaction-level reference model, directed and random traffic.
module tb_mem_port_arb;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ma_req;
  logic          ma_we;
  logic [AW-1:0] ma_addr;
  logic [DW-1:0] ma_wdata;
  logic          ma_gnt;
  logic          ma_rvalid;
  logic [DW-1:0] ma_rdata;
  logic          flush;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arb #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_STREAK(MS)
  ) dut (
    .iw_clk      (clk),
    .iw_rst      (rst_n),
    .iw_if_req   (if_req),
    .iw_if_addr  (if_addr),
    .ow_if_gnt   (if_gnt),
    .ow_if_rvalid(if_rvalid),
    .ow_if_rdata (if_rdata),
    .iw_ma_req   (ma_req),
    .iw_ma_we    (ma_we),
    .iw_ma_addr  (ma_addr),
    .iw_ma_wdata (ma_wdata),
    .ow_ma_gnt   (ma_gnt),
    .ow_ma_rvalid(ma_rvalid),
    .ow_ma_rdata (ma_rdata),
    .iw_flush    (flush),
    .ow_mem_we   (mem_we),
    .ow_mem_addr (mem_addr),
    .ow_mem_wdata(mem_wdata),
    .iw_mem_rdata(mem_rdata)
  );

  // Untouched words read as {addr, ~addr}, so expected contents need no preload.
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory device driven by the DUT.
  logic [DW-1:0] mem [256];
  bit            mem_wr [256];

  function automatic logic [DW-1:0] mem_peek(input logic [AW-1:0] a);
    return mem_wr[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]    <= mem_wdata;
      mem_wr[mem_addr] <= 1'b1;
    end
    mem_rdata <= mem_peek(mem_addr);
  end

  // Reference model: expected memory image, MA wins while fetch waits, last read grant.
  logic [DW-1:0] ref_mem [256];
  bit            ref_wr [256];
  int            m_wait = 0;
  bit            m_pend_if = 1'b0;
  bit            m_pend_ma = 1'b0;
  logic [AW-1:0] m_pend_addr = '0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

  logic          s_rst = 1'b0;
  logic          s_if_g = 1'b0;
  logic          s_ma_g = 1'b0;
  logic          s_we = 1'b0;
  logic          s_ifreq = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [DW-1:0] s_wdata = '0;

  always @(negedge clk) begin : cmp
    logic          e_if, e_ma, e_we, e_ifv, e_mav;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    e_if = 1'b0; e_ma = 1'b0; e_we = 1'b0; e_ifv = 1'b0; e_mav = 1'b0;
    e_addr = '0; e_wd = '0;
    if (rst_n) begin
      e_ma   = ma_req && !(if_req && (m_wait >= MS));
      e_if   = if_req && !e_ma;
      e_addr = e_ma ? ma_addr : (e_if ? if_addr : '0);
      e_we   = e_ma && ma_we;
      e_wd   = e_ma ? ma_wdata : '0;
      e_ifv  = m_pend_if && !flush;
      e_mav  = m_pend_ma;
    end
    chk("if_gnt", 32'(if_gnt), 32'(e_if));
    chk("ma_gnt", 32'(ma_gnt), 32'(e_ma));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    chk("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
    chk("ma_rvalid", 32'(ma_rvalid), 32'(e_mav));
    if (e_ifv) chk("if_rdata", 32'(if_rdata), 32'(ref_rd(m_pend_addr)));
    if (e_mav) chk("ma_rdata", 32'(ma_rdata), 32'(ref_rd(m_pend_addr)));
    s_rst   <= rst_n;
    s_if_g  <= e_if;
    s_ma_g  <= e_ma;
    s_we    <= e_we;
    s_ifreq <= if_req;
    s_addr  <= e_addr;
    s_wdata <= e_wd;
  end

  always @(posedge clk) begin
    if (!s_rst) begin
      m_wait    <= 0;
      m_pend_if <= 1'b0;
      m_pend_ma <= 1'b0;
    end else begin
      if (s_we) begin
        ref_mem[s_addr] <= s_wdata;
        ref_wr[s_addr]  <= 1'b1;
      end
      m_pend_if   <= s_if_g;
      m_pend_ma   <= s_ma_g && !s_we;
      m_pend_addr <= s_addr;
      if (s_if_g || !s_ifreq) m_wait <= 0;
      else if (s_ma_g)        m_wait <= (m_wait < MS) ? m_wait + 1 : MS;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    if_req = 1'b0; ma_req = 1'b0; ma_we = 1'b0; flush = 1'b0;
  endtask

  initial begin : stim
    int rst_cnt;
    rst_cnt = 0;
    rst_n = 1'b0;
    idle_in();
    if_addr = '0; ma_addr = '0; ma_wdata = '0;
    // Write attempt held during reset must never reach memory.
    ma_req = 1'b1; ma_we = 1'b1; ma_addr = 8'h41; ma_wdata = 16'hBEEF;
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_ma_gnt", 32'(ma_gnt), 0);
    chk("rst_if_rvalid", 32'(if_rvalid), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    idle_in();

    // IF-only streaming reads.
    if_req = 1'b1; if_addr = 8'h10;
    @(negedge clk);
    chk("if_seq_gnt", 32'(if_gnt), 1);
    chk("if_seq_addr", 32'(mem_addr), 'h10);
    cyc(); if_addr = 8'h11;
    @(negedge clk);
    chk("if_seq_rv1", 32'(if_rvalid), 1);
    chk("if_seq_rd1", 32'(if_rdata), 'h10EF);
    cyc(); if_addr = 8'h12;
    @(negedge clk);
    chk("if_seq_rd2", 32'(if_rdata), 'h11EE);
    cyc(); if_req = 1'b0;
    @(negedge clk);
    chk("if_seq_rd3", 32'(if_rdata), 'h12ED);
    chk("if_seq_ma_rv", 32'(ma_rvalid), 0);

    // MA write then read back.
    cyc(); ma_req = 1'b1; ma_we = 1'b1; ma_addr = 8'h20; ma_wdata = 16'h0ABC;
    @(negedge clk);
    chk("wr_mem_we", 32'(mem_we), 1);
    cyc(); ma_we = 1'b0;
    @(negedge clk);
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("rd_ma_rv_early", 32'(ma_rvalid), 0);
    cyc(); ma_req = 1'b0;
    @(negedge clk);
    chk("rd_ma_rv", 32'(ma_rvalid), 1);
    chk("rd_ma_data", 32'(ma_rdata), 'h0ABC);

    // Contention: four MA grants then one IF grant, repeating.
    cyc(); if_req = 1'b1; if_addr = 8'h50; ma_req = 1'b1; ma_we = 1'b0; ma_addr = 8'h60;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) cyc();
      @(negedge clk);
      chk("streak_ma", 32'(ma_gnt), 32'((k % 5) != 4));
      chk("streak_if", 32'(if_gnt), 32'((k % 5) == 4));
    end
    cyc(); idle_in();

    // Flush on redirect with a new fetch in the same cycle.
    cyc(); if_req = 1'b1; if_addr = 8'h30;
    @(negedge clk);
    chk("fl_gnt0", 32'(if_gnt), 1);
    cyc(); if_addr = 8'h31; flush = 1'b1;
    @(negedge clk);
    chk("fl_gnt1", 32'(if_gnt), 1);
    chk("fl_masked", 32'(if_rvalid), 0);
    cyc(); if_req = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fl_new_rv", 32'(if_rvalid), 1);
    chk("fl_new_rd", 32'(if_rdata), 'h31CE);

    // Reset with an MA read response outstanding.
    cyc(); ma_req = 1'b1; ma_we = 1'b0; ma_addr = 8'h40;
    @(negedge clk);
    chk("mr_gnt", 32'(ma_gnt), 1);
    cyc(); rst_n = 1'b0; ma_we = 1'b1; ma_addr = 8'h41; ma_wdata = 16'hDEAD;
    @(negedge clk);
    chk("mr_rv_killed", 32'(ma_rvalid), 0);
    chk("mr_we_blocked", 32'(mem_we), 0);
    cyc();
    @(negedge clk);
    chk("mr_we_blocked2", 32'(mem_we), 0);
    cyc(); rst_n = 1'b1; ma_we = 1'b0; ma_addr = 8'h40;
    @(negedge clk);
    chk("mr_regnt", 32'(ma_gnt), 1);
    cyc(); ma_req = 1'b0;
    @(negedge clk);
    chk("mr_rv", 32'(ma_rvalid), 1);
    chk("mr_rd", 32'(ma_rdata), 'h40BF);
    chk("mr_mem41", 32'(mem_peek(8'h41)), 'h41BE);

    // Random traffic; requesters hold until granted.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (rst_cnt > 0) begin
        rst_n = 1'b0;
        rst_cnt--;
      end else begin
        rst_n = 1'b1;
        if ($urandom_range(0, 299) == 0) begin
          rst_n = 1'b0;
          rst_cnt = 1;
        end
      end
      if (!if_req || s_if_g) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = AW'($urandom);
      end
      if (!ma_req || s_ma_g) begin
        ma_req   = ($urandom_range(0, 2) != 0);
        ma_we    = ($urandom_range(0, 1) == 1);
        ma_addr  = AW'($urandom);
        ma_wdata = DW'($urandom);
      end
      flush = ($urandom_range(0, 7) == 0);
    end
    cyc(); rst_n = 1'b1; idle_in();
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
